reaction_ctrl: RTL and testbench
================================

// Module: reaction_ctrl
// PURPOSE
//  Sequencer for the reaction game, driven by the 1 kHz clk_ms from the clock divider.
//  On a start press it waits a pseudo-random delay, raises the GO lamp, then counts ms
//  until the react press and publishes the reaction time.
//  Detects false starts (press before GO) and timeouts.
//  Sits between the divider, the button synchronisers and the 7-seg display driver.
// PARAMETERS
//  DELAY_MIN_MS  1000   minimum ARMED wait in ms
//  DELAY_MASK    2047   AND-mask on LFSR; wait = DELAY_MIN_MS + (lfsr & DELAY_MASK), max 3047 ms
//  MAX_MS        9999   reaction count limit; reaching it ends the round as timeout
//  RES_W         14     width of result_ms and internal counters (must hold MAX_MS and max delay)
//  LFSR_SEED     16'hACE1  LFSR reset value, never zero
// PORTS
//  clk           in   1      system clock (CLOCK_50)
//  rst_n         in   1      synchronous, active-low reset
//  clk_ms        in   1      1 kHz square wave from the clock divider
//  start         in   1      start button, already synchronised/debounced, active-high level
//  react         in   1      react button, already synchronised/debounced, active-high level
//  led_go        out  1      GO lamp, high only in state GO
//  busy          out  1      high in ARMED or GO
//  result_ms     out  RES_W  last reaction time in ms, held until next start
//  result_valid  out  1      one-clk pulse when result_ms updates
//  foul          out  1      high in FOUL until next start
//  timeout       out  1      high when last round hit MAX_MS, cleared on next start
// BEHAVIOUR
//  - All regs update on posedge clk. rst_n low at an edge: state=IDLE, all outputs 0,
//    counters 0, lfsr=LFSR_SEED. Reset mid-round aborts the round, no result_valid.
//  - ms_tick: one-clk pulse on the rising edge of clk_ms (registered previous value).
//    start_e/react_e: one-clk rising-edge pulses of start/react.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk, so the delay depends on
//    press timing.
//  - States: IDLE, ARMED, GO, DONE, FOUL.
//  - IDLE/DONE/FOUL + start_e -> ARMED:
//    - dly_cnt <= DELAY_MIN_MS + (lfsr & DELAY_MASK).
//    - foul, timeout and result_valid cleared; result_ms held.
//  - ARMED:
//    - react_e -> FOUL (foul=1). React wins over a same-cycle expiring tick.
//    - Else on ms_tick: dly_cnt--. If dly_cnt==1 -> GO, rt_cnt<=0.
//      led_go rises at the clk edge that enters GO.
//  - GO:
//    - react_e -> DONE, result_ms<=rt_cnt. A same-cycle ms_tick is not counted.
//    - Else on ms_tick: rt_cnt++. If rt_cnt+1==MAX_MS -> DONE, result_ms<=MAX_MS, timeout=1.
//    - Any entry into DONE from GO pulses result_valid for exactly 1 clk.
//  - start_e in ARMED/GO is ignored. react_e in IDLE/DONE/FOUL is ignored.
//  - start_e and react_e together in IDLE: start wins (-> ARMED), react dropped.
//  - Held buttons generate no repeat edges.
//  - busy = (state==ARMED)|(state==GO). Both busy and led_go are registered with the state.
// STRUCTURE
//  - Package reaction_pkg: state encoding (5 states, 3-bit) and LFSR tap constant.
//  - One sub-module, reaction_lfsr (16-bit, seed param, enable=1): separately reusable.
//  - Edge detectors and counters are inline.
// TESTING (divider at countQ=20; DELAY_MIN_MS=4, DELAY_MASK=0, MAX_MS=15)
//  1. rst_n=0 for 3 clks mid-GO -> next edge: led_go=busy=foul=timeout=result_valid=0,
//     result_ms=0.
//  2. Pulse start, react 7 ms_ticks after led_go rises -> led_go rises after 4th tick;
//     result_ms=7, result_valid 1 clk, led_go=0.
//  3. Pulse start, react after 2 ticks -> foul=1, led_go never rises, no result_valid,
//     result_ms unchanged.
//  4. Pulse start, never react -> after 15 GO ticks: result_ms=15, timeout=1,
//     result_valid 1 clk.
//  5. In GO with rt_cnt=5: react_e and ms_tick same clk -> result_ms=5.
//     start_e during GO -> no state change.
//  6. Hold start high across round end -> no re-arm until start released and pressed again.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-game sequencer.
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_FOUL  = 3'd4
  } state_e;

  localparam int          LFSR_W    = 16;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/reaction_ctrl_if.sv
// Button/tick inputs and lamp/result outputs of the reaction sequencer.
interface reaction_ctrl_if #(
  parameter int RES_W = 14
);
  logic             clk_ms;
  logic             start;
  logic             react;
  logic             led_go;
  logic             busy;
  logic [RES_W-1:0] result_ms;
  logic             result_valid;
  logic             foul;
  logic             timeout;

  modport master (
    output clk_ms, start, react,
    input  led_go, busy, result_ms, result_valid, foul, timeout
  );

  modport slave (
    input  clk_ms, start, react,
    output led_go, busy, result_ms, result_valid, foul, timeout
  );
endinterface

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; new value every enabled clk, no backpressure.
module reaction_lfsr
  import reaction_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb;

  assign fb     = ^(lfsr_q & LFSR_TAPS);
  assign lfsr_o = lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-game sequencer: random arm delay, GO lamp, ms reaction count, foul/timeout.
// All outputs registered (1 clk after the deciding edge); inputs are never backpressured.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int          DELAY_MIN_MS = 1000,
  parameter int          DELAY_MASK   = 2047,
  parameter int          MAX_MS       = 9999,
  parameter int          RES_W        = 14,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  reaction_ctrl_if.slave   bus
);

  localparam logic [LFSR_W-1:0] MASK16 = LFSR_W'(DELAY_MASK);
  localparam logic [RES_W-1:0]  ONE    = RES_W'(1);
  localparam logic [RES_W-1:0]  MAX_R  = RES_W'(MAX_MS);
  localparam logic [RES_W-1:0]  MAX_M1 = RES_W'(MAX_MS - 1);

  logic              clk_ms_q, start_q, react_q;
  logic              ms_tick, start_e, react_e;
  logic [LFSR_W-1:0] lfsr;
  logic [RES_W-1:0]  dly_init_d;

  state_e            state_q;
  logic [RES_W-1:0]  dly_cnt_q, rt_cnt_q, result_q;
  logic              rv_q, foul_q, timeout_q, led_go_q, busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_ms_q <= 1'b0;
      start_q  <= 1'b0;
      react_q  <= 1'b0;
    end else begin
      clk_ms_q <= bus.clk_ms;
      start_q  <= bus.start;
      react_q  <= bus.react;
    end
  end

  assign ms_tick = bus.clk_ms & ~clk_ms_q;
  assign start_e = bus.start  & ~start_q;
  assign react_e = bus.react  & ~react_q;

  reaction_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .lfsr_o (lfsr)
  );

  assign dly_init_d = RES_W'(DELAY_MIN_MS) + RES_W'(lfsr & MASK16);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dly_cnt_q <= '0;
      rt_cnt_q  <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      foul_q    <= 1'b0;
      timeout_q <= 1'b0;
      led_go_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_FOUL: begin
          if (start_e) begin
            state_q   <= S_ARMED;
            dly_cnt_q <= dly_init_d;
            foul_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_ARMED: begin
          // A press wins over a tick that would have expired the delay.
          if (react_e) begin
            state_q <= S_FOUL;
            foul_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (ms_tick) begin
            dly_cnt_q <= dly_cnt_q - ONE;
            if (dly_cnt_q == ONE) begin
              state_q  <= S_GO;
              rt_cnt_q <= '0;
              led_go_q <= 1'b1;
            end
          end
        end
        S_GO: begin
          if (react_e) begin
            state_q  <= S_DONE;
            result_q <= rt_cnt_q;
            rv_q     <= 1'b1;
            led_go_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (ms_tick) begin
            rt_cnt_q <= rt_cnt_q + ONE;
            if (rt_cnt_q == MAX_M1) begin
              state_q   <= S_DONE;
              result_q  <= MAX_R;
              timeout_q <= 1'b1;
              rv_q      <= 1'b1;
              led_go_q  <= 1'b0;
              busy_q    <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          led_go_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led_go       = led_go_q;
  assign bus.busy         = busy_q;
  assign bus.result_ms    = result_q;
  assign bus.result_valid = rv_q;
  assign bus.foul         = foul_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: stimulus table, directed corner sequences, random run vs. a round-level model.
module tb_reaction_ctrl;

  localparam int DMIN  = 4;
  localparam int MAXMS = 15;
  localparam int RW    = 14;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reaction_ctrl_if #(.RES_W(RW)) bus ();

  reaction_ctrl #(
    .DELAY_MIN_MS (DMIN),
    .DELAY_MASK   (0),
    .MAX_MS       (MAXMS),
    .RES_W        (RW),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Round-level model: a round is "armed" with a remaining tick budget, then "running"
  // with an elapsed tick count; outcomes are a reaction time, a foul or a timeout.
  bit m_armed, m_running, m_foul, m_to, m_rv;
  int m_left, m_elapsed, m_res;
  bit p_s, p_r, p_m;

  function automatic void model_step(bit rst, bit s, bit r, bit m);
    bit tk, se, re;
    if (rst) begin
      m_armed = 0; m_running = 0; m_foul = 0; m_to = 0; m_rv = 0;
      m_left = 0; m_elapsed = 0; m_res = 0;
      p_s = 0; p_r = 0; p_m = 0;
      return;
    end
    tk = m && !p_m;
    se = s && !p_s;
    re = r && !p_r;
    m_rv = 0;
    if (m_armed) begin
      if (re) begin
        m_armed = 0; m_foul = 1;
      end else if (tk) begin
        m_left--;
        if (m_left == 0) begin
          m_armed = 0; m_running = 1; m_elapsed = 0;
        end
      end
    end else if (m_running) begin
      if (re) begin
        m_running = 0; m_res = m_elapsed; m_rv = 1;
      end else if (tk) begin
        m_elapsed++;
        if (m_elapsed == MAXMS) begin
          m_running = 0; m_res = MAXMS; m_to = 1; m_rv = 1;
        end
      end
    end else if (se) begin
      m_armed = 1; m_left = DMIN; m_foul = 0; m_to = 0;
    end
    p_s = s; p_r = r; p_m = m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model.led_go", bus.led_go, m_running);
    chk("model.busy", bus.busy, m_armed | m_running);
    chk("model.result_valid", bus.result_valid, m_rv);
    chk("model.foul", bus.foul, m_foul);
    chk("model.timeout", bus.timeout, m_to);
    chk("model.result_ms", bus.result_ms, m_res);
  endtask

  task automatic cyc(input bit s, input bit r, input bit m);
    bus.start  = s;
    bus.react  = r;
    bus.clk_ms = m;
    @(posedge clk);
    #1;
    model_step(!rst_n, s, r, m);
    cmp_model();
  endtask

  task automatic ticks(input int n, input bit s);
    for (int k = 0; k < n; k++) begin
      cyc(s, 1'b0, 1'b1);
      cyc(s, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    bit s, r, m;
    bit go, busy, rv, foul, to;
    int res;
  } vec_t;
  vec_t tbl[$];

  function automatic void push(bit s, bit r, bit m, bit go, bit busy, bit rv, bit foul,
                               bit to, int res);
    vec_t v;
    v.s = s; v.r = r; v.m = m;
    v.go = go; v.busy = busy; v.rv = rv; v.foul = foul; v.to = to; v.res = res;
    tbl.push_back(v);
  endfunction

  initial begin
    bit rs, rr, rm;
    int div;

    // Normal round: GO after the 4th tick, react after 7 GO ticks.
    push(1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      push(0, 0, 1, k == 4, 1, 0, 0, 0, 0);
      push(0, 0, 0, k == 4, 1, 0, 0, 0, 0);
    end
    for (int k = 1; k <= 7; k++) begin
      push(0, 0, 1, 1, 1, 0, 0, 0, 0);
      push(0, 0, 0, 1, 1, 0, 0, 0, 0);
    end
    push(0, 1, 0, 0, 0, 1, 0, 0, 7);
    push(0, 0, 0, 0, 0, 0, 0, 0, 7);

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0);
    chk("rst.led_go", bus.led_go, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.result_ms", bus.result_ms, 0);
    chk("rst.result_valid", bus.result_valid, 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    chk("idle.react_ignored", bus.busy, 0);
    cyc(1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].r, tbl[i].m);
      chk($sformatf("tbl[%0d].led_go", i), bus.led_go, tbl[i].go);
      chk($sformatf("tbl[%0d].busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("tbl[%0d].result_valid", i), bus.result_valid, tbl[i].rv);
      chk($sformatf("tbl[%0d].foul", i), bus.foul, tbl[i].foul);
      chk($sformatf("tbl[%0d].timeout", i), bus.timeout, tbl[i].to);
      chk($sformatf("tbl[%0d].result_ms", i), bus.result_ms, tbl[i].res);
    end

    // False start after 2 ticks; result from the previous round is kept.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("foul.foul", bus.foul, 1);
    chk("foul.busy", bus.busy, 0);
    chk("foul.result_valid", bus.result_valid, 0);
    chk("foul.result_ms", bus.result_ms, 7);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(5, 1'b0);
    chk("foul.no_go", bus.led_go, 0);
    chk("foul.held", bus.foul, 1);

    // Timeout after 15 GO ticks.
    cyc(1'b1, 1'b0, 1'b0);
    chk("to.foul_cleared", bus.foul, 0);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(4, 1'b0);
    chk("to.go", bus.led_go, 1);
    ticks(14, 1'b0);
    chk("to.still_go", bus.led_go, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("to.result_valid", bus.result_valid, 1);
    chk("to.timeout", bus.timeout, 1);
    chk("to.result_ms", bus.result_ms, MAXMS);
    chk("to.led_go", bus.led_go, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("to.rv_one_clk", bus.result_valid, 0);
    chk("to.timeout_held", bus.timeout, 1);

    // Start during GO ignored; react with a same-cycle tick reports 5.
    cyc(1'b1, 1'b0, 1'b0);
    chk("go5.timeout_cleared", bus.timeout, 0);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(4, 1'b0);
    ticks(5, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("go5.start_ignored", bus.led_go, 1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("go5.result_ms", bus.result_ms, 5);
    chk("go5.result_valid", bus.result_valid, 1);
    cyc(1'b0, 1'b0, 1'b0);

    // Start held across the round end must not re-arm.
    cyc(1'b1, 1'b0, 1'b0);
    ticks(4, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("hold.done_rv", bus.result_valid, 1);
    chk("hold.result_ms", bus.result_ms, 0);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(3, 1'b1);
    chk("hold.no_rearm", bus.busy, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("hold.rearm", bus.busy, 1);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset in the middle of GO.
    ticks(6, 1'b0);
    chk("midrst.in_go", bus.led_go, 1);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst.led_go", bus.led_go, 0);
    chk("midrst.busy", bus.busy, 0);
    chk("midrst.foul", bus.foul, 0);
    chk("midrst.timeout", bus.timeout, 0);
    chk("midrst.result_valid", bus.result_valid, 0);
    chk("midrst.result_ms", bus.result_ms, 0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    ticks(3, 1'b0);
    chk("midrst.idle", bus.busy, 0);

    // Random buttons with a 20-clk half-period ms clock and rare resets.
    rs = 0; rr = 0; rm = 0; div = 0;
    for (int i = 0; i < 20000; i++) begin
      div++;
      if (div == 20) begin
        div = 0;
        rm = !rm;
      end
      if ($urandom_range(99) == 0)  rs = !rs;
      if ($urandom_range(299) == 0) rr = !rr;
      rst_n = ($urandom_range(4999) != 0);
      cyc(rs, rr, rm);
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
